// File: rtl/lvds_bitslip_ctrl.sv
// Word-alignment controller for an LVDS deserializer: hunts for PATTERN by
// issuing single-cycle bitslip requests, then declares and supervises lock.
module lvds_bitslip_ctrl #(
   parameter int                SIZE          = 8,
   parameter logic [SIZE-1:0]   PATTERN       = 8'hF0,
   parameter int                SETTLE_CYCLES = 4,
   parameter int                LOCK_COUNT    = 16,
   parameter int                UNLOCK_COUNT  = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [SIZE-1:0]           frame_in,
   input  logic                      enable,
   output logic                      bitslip,
   output logic                      locked,
   output logic [$clog2(SIZE):0]     slip_count,
   output logic                      align_err
);

   localparam int SW = $clog2(SIZE) + 1;

   localparam logic [7:0]    LOCK_LAST   = 8'(LOCK_COUNT - 1);
   localparam logic [7:0]    UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);
   localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0] SLIP_LAST   = SW'(SIZE - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      SLIP   = 3'd2,
      SETTLE = 3'd3,
      LOCKED = 3'd4
   } state_t;

   state_t          state_r, next_state_s;
   logic [7:0]      match_cnt_r, match_cnt_s;
   logic [7:0]      miss_cnt_r, miss_cnt_s;
   logic [7:0]      settle_cnt_r, settle_cnt_s;
   logic [SW-1:0]   slip_count_r, slip_count_s;
   logic            align_err_r, align_err_s;
   logic            bitslip_r, bitslip_s;
   logic            locked_r, locked_s;
   logic            match_s;

   assign match_s = (frame_in == PATTERN);

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r      <= IDLE;
         match_cnt_r  <= 8'd0;
         miss_cnt_r   <= 8'd0;
         settle_cnt_r <= 8'd0;
         slip_count_r <= {SW{1'b0}};
         align_err_r  <= 1'b0;
         bitslip_r    <= 1'b0;
         locked_r     <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         match_cnt_r  <= match_cnt_s;
         miss_cnt_r   <= miss_cnt_s;
         settle_cnt_r <= settle_cnt_s;
         slip_count_r <= slip_count_s;
         align_err_r  <= align_err_s;
         bitslip_r    <= bitslip_s;
         locked_r     <= locked_s;
      end
   end

   // Next-state decode; a low enable returns to IDLE from any state
   always_comb begin
      next_state_s = state_r;
      if (!enable) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:   next_state_s = CHECK;
            CHECK: begin
               if (!match_s)
                  next_state_s = SLIP;
               else if (match_cnt_r == LOCK_LAST)
                  next_state_s = LOCKED;
               else
                  next_state_s = CHECK;
            end
            SLIP:   next_state_s = SETTLE;
            SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST)
                  next_state_s = CHECK;
               else
                  next_state_s = SETTLE;
            end
            LOCKED: begin
               if (!match_s && (miss_cnt_r == UNLOCK_LAST))
                  next_state_s = CHECK;
               else
                  next_state_s = LOCKED;
            end
            default: next_state_s = IDLE;
         endcase
      end
   end

   // Counter updates and next values of the registered outputs
   always_comb begin
      match_cnt_s  = match_cnt_r;
      miss_cnt_s   = miss_cnt_r;
      settle_cnt_s = settle_cnt_r;
      slip_count_s = slip_count_r;
      align_err_s  = align_err_r;
      bitslip_s    = (next_state_s == SLIP);
      // locked rises one cycle after entering LOCKED and drops with the exit
      locked_s     = (state_r == LOCKED) && (next_state_s == LOCKED);

      case (state_r)
         IDLE: begin
            match_cnt_s  = 8'd0;
            miss_cnt_s   = 8'd0;
            settle_cnt_s = 8'd0;
            if (enable) begin
               slip_count_s = {SW{1'b0}};
               align_err_s  = 1'b0;
            end else begin
               slip_count_s = slip_count_r;
               align_err_s  = align_err_r;
            end
         end
         CHECK: begin
            miss_cnt_s   = 8'd0;
            settle_cnt_s = 8'd0;
            if (match_s)
               match_cnt_s = match_cnt_r + 8'd1;
            else
               match_cnt_s = 8'd0;
         end
         SLIP: begin
            settle_cnt_s = 8'd0;
            match_cnt_s  = 8'd0;
         end
         SETTLE: begin
            if (next_state_s == SETTLE)
               settle_cnt_s = settle_cnt_r + 8'd1;
            else
               settle_cnt_s = 8'd0;
         end
         LOCKED: begin
            match_cnt_s = 8'd0;
            if (match_s)
               miss_cnt_s = 8'd0;
            else
               miss_cnt_s = miss_cnt_r + 8'd1;
         end
         default: begin
            match_cnt_s  = 8'd0;
            miss_cnt_s   = 8'd0;
            settle_cnt_s = 8'd0;
         end
      endcase

      // slip_count advances with the pulse; wrapping means a full fruitless rotation
      if (next_state_s == SLIP) begin
         if (slip_count_r == SLIP_LAST) begin
            slip_count_s = {SW{1'b0}};
            align_err_s  = 1'b1;
         end else begin
            slip_count_s = slip_count_r + {{(SW-1){1'b0}}, 1'b1};
         end
      end else begin
         slip_count_s = slip_count_s;
      end
   end

   assign bitslip    = bitslip_r;
   assign locked     = locked_r;
   assign slip_count = slip_count_r;
   assign align_err  = align_err_r;

endmodule

// File: tb/tb_lvds_bitslip_ctrl.sv
// Directed self-checking bench for lvds_bitslip_ctrl; the deserializer is
// modelled as a frame rotated by one bit per bitslip pulse.
module tb_lvds_bitslip_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] frame_in;
   logic       enable;
   logic       bitslip;
   logic       locked;
   logic [3:0] slip_count;
   logic       align_err;

   int n_checks = 0;
   int n_pass   = 0;

   lvds_bitslip_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .frame_in   (frame_in),
      .enable     (enable),
      .bitslip    (bitslip),
      .locked     (locked),
      .slip_count (slip_count),
      .align_err  (align_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   initial begin
      int pulses;
      int low_run;
      int gap1;
      int gap2;
      int off;
      int err_at7;

      // Reset state
      resetn = 1'b0; enable = 1'b0; frame_in = 8'hF0;
      tick(); tick(); tick();
      check("rst_bitslip", bitslip, 0);
      check("rst_locked", locked, 0);
      check("rst_slip_count", slip_count, 0);
      check("rst_align_err", align_err, 0);
      resetn = 1'b1;
      tick();
      check("idle_locked", locked, 0);

      // Aligned input: lock 17 edges after enable is first sampled
      enable = 1'b1;
      tick();
      pulses = 0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (bitslip) pulses++;
         if (k == 16) check("aligned_locked_e16", locked, 0);
         if (k == 17) check("aligned_locked_e17", locked, 1);
      end
      check("aligned_pulses", pulses, 0);
      check("aligned_slip_count", slip_count, 0);

      // Lock tolerance: 3 misses + 1 match keeps lock, then 4 misses unlock
      frame_in = 8'h00;
      tick(); tick(); tick();
      check("tol_locked_3miss", locked, 1);
      frame_in = 8'hF0;
      tick();
      check("tol_locked_match", locked, 1);
      frame_in = 8'h00;
      tick(); tick(); tick();
      check("tol_locked_3miss_b", locked, 1);
      tick();
      check("tol_unlock", locked, 0);
      check("tol_no_slip_yet", bitslip, 0);
      check("tol_slip_preserved", slip_count, 0);
      tick();
      check("tol_slip_pulse", bitslip, 1);
      check("tol_slip_count", slip_count, 1);

      // enable dropped while in SLIP: pulse ends, IDLE, slip_count held
      enable = 1'b0;
      tick();
      check("abort_bitslip", bitslip, 0);
      check("abort_locked", locked, 0);
      check("abort_slip_count", slip_count, 1);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bitslip) pulses++;
      end
      check("abort_no_more_pulses", pulses, 0);
      check("abort_slip_held", slip_count, 1);

      // Offset input, 3 slips away from alignment
      off = 3;
      frame_in = rotl8(8'hF0, off);
      enable = 1'b1;
      pulses = 0; low_run = 0; gap1 = -1; gap2 = -1;
      for (int k = 0; k < 200 && !locked; k++) begin
         tick();
         if (bitslip) begin
            pulses++;
            if (pulses == 2) gap1 = low_run;
            if (pulses == 3) gap2 = low_run;
            low_run = 0;
            if (off > 0) off--;
            frame_in = rotl8(8'hF0, off);
         end else begin
            low_run++;
         end
      end
      check("offset_pulses", pulses, 3);
      check("offset_gap1", gap1, 5);
      check("offset_gap2", gap2, 5);
      check("offset_slip_count", slip_count, 3);
      check("offset_locked", locked, 1);
      check("offset_align_err", align_err, 0);

      // Unalignable input: a full rotation sets align_err
      enable = 1'b0;
      tick();
      frame_in = 8'h00;
      enable = 1'b1;
      pulses = 0; err_at7 = -1;
      for (int k = 0; k < 200 && pulses < 8; k++) begin
         tick();
         if (bitslip) begin
            pulses++;
            if (pulses == 7) err_at7 = int'(align_err);
         end
      end
      check("unalign_pulses", pulses, 8);
      check("unalign_err_at7", err_at7, 0);
      check("unalign_err_at8", align_err, 1);
      check("unalign_slip_count", slip_count, 0);
      check("unalign_locked", locked, 0);
      enable = 1'b0;
      tick();
      check("unalign_err_held_idle", align_err, 1);
      enable = 1'b1;
      tick();
      check("unalign_err_cleared", align_err, 0);

      // Reset during SETTLE
      tick();
      check("settle_pre_pulse", bitslip, 1);
      tick(); tick();
      resetn = 1'b0;
      tick();
      check("settle_rst_bitslip", bitslip, 0);
      check("settle_rst_locked", locked, 0);
      check("settle_rst_slip_count", slip_count, 0);
      check("settle_rst_align_err", align_err, 0);

      // Enable acted on from the first edge after reset release
      frame_in = 8'hF0;
      resetn = 1'b1;
      for (int k = 0; k < 17; k++) tick();
      check("post_rst_locked_e16", locked, 0);
      tick();
      check("post_rst_locked_e17", locked, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
